mips_fetch_unit: RTL and testbench
==================================

// Module: mips_fetch_unit
// PURPOSE
//  Instruction fetch sequencer for the single-issue MIPS core; the producer side of the control-unit interface.
//  Holds the PC and fetches one word at a time over a req/ack instruction-memory port.
//  Presents Instruction and InstrOpCode to the decoder.
//  Consumes Jump/Branch/JumpReg back from decode and the datapath Zero flag to choose the next PC.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; must be word aligned
//  MAX_WAIT  255            max REQ cycles without imem_ack before a timeout error; legal range 1..255
// PORTS
//  clk          in   1   single clock; all state on rising edge
//  reset        in   1   asynchronous, active-high reset
//  imem_req     out  1   fetch request; held until ack
//  imem_addr    out  32  fetch address; [1:0] always 2'b00
//  imem_ack     in   1   rdata valid this cycle; ignored unless imem_req=1
//  imem_rdata   in   32  fetched instruction word
//  Instruction  out  32  held instruction word
//  InstrOpCode  out  6   Instruction[31:26], feeds control decode
//  InstrValid   out  1   Instruction valid, awaiting retire
//  InstrReady   in   1   datapath retires current instruction this cycle
//  Jump         in   1   j/jal from decode
//  Branch       in   1   beq/bne from decode
//  Zero         in   1   ALU zero flag for the current instruction
//  JumpReg      in   1   jr from datapath funct decode
//  RegTarget    in   32  rs value for jr
//  LinkPC       out  32  PC+4 of current instruction (jal link value)
//  InstrCount   out  32  retired instruction count, wraps mod 2^32
//  FetchError   out  1   sticky: timeout or misaligned jr target
// BEHAVIOUR
//  Reset values:
//   - PC=RESET_PC, imem_addr=RESET_PC, LinkPC=RESET_PC+4
//   - imem_req=0, InstrValid=0, Instruction=0, InstrOpCode=0, InstrCount=0, FetchError=0
//   - state=IDLE, wait counter=0
//  State machine:
//   - IDLE: unconditionally -> REQ on the first edge after reset release.
//   - REQ: imem_req=1, imem_addr=PC.
//     - Edge with imem_ack=1: Instruction<=imem_rdata, InstrValid<=1, -> HOLD.
//     - Edge without ack: wait counter +1. If the counter was MAX_WAIT-1 -> ERR.
//     - An ack in any of the first MAX_WAIT REQ cycles is accepted.
//   - HOLD: imem_req=0, InstrValid=1, Instruction stable.
//     - Edge with InstrReady=1: PC<=next_pc, InstrCount+1, InstrValid<=0, wait counter<=0, -> REQ.
//     - Decode inputs are sampled only at that edge.
//   - ERR: imem_req=0, InstrValid=0, FetchError=1; held until reset.
//  Latency:
//   - imem_req asserts 1 cycle after reset release.
//   - InstrValid asserts 1 cycle after the ack edge.
//   - Zero-wait throughput: one instruction per 2 cycles with InstrReady tied high.
//  next_pc priority (all arithmetic mod 2^32, wrap allowed):
//   1. JumpReg: RegTarget. If RegTarget[1:0]!=0 -> ERR instead; PC and InstrCount unchanged.
//   2. Jump: {LinkPC[31:28], Instruction[25:0], 2'b00}.
//   3. Branch taken: LinkPC + {{14{Instruction[15]}}, Instruction[15:0], 2'b00}.
//      - Taken = Branch & (Zero XOR InstrOpCode[0]); beq 000100 taken on Zero=1, bne 000101 on Zero=0.
//   4. Otherwise: LinkPC.
//  Other rules:
//   - LinkPC is combinational PC+4; PC 32'hFFFF_FFFC gives LinkPC 0.
//   - Ack while imem_req=0 (IDLE/HOLD/ERR) is ignored; at most one request is outstanding.
//   - Reset mid-REQ or mid-HOLD aborts immediately (async); the pending fetch is discarded.
// TESTING
//  1. Reset, RESET_PC=0, ack same cycle as req, InstrReady=1.
//     -> imem_addr 0,4,8,... every 2 cycles; InstrCount increments per retire.
//  2. ack delayed 3 cycles, InstrReady held low 5 cycles in HOLD.
//     -> addr/req stable while waiting; Instruction stable; no retire until InstrReady=1.
//  3. beq at PC=0x10, imm=0xFFFF: Zero=1 -> next addr 0x10; Zero=0 -> 0x14.
//     bne at PC=0x10, imm=0xFFFF: Zero=0 -> 0x10.
//  4. jal 0x0C000040 at PC=0x20 -> next addr 0x100, LinkPC=0x24.
//     JumpReg with Jump=1, RegTarget=0x200 -> next addr 0x200 (JumpReg wins).
//  5. JumpReg, RegTarget=0x202 -> FetchError=1, imem_req stays 0.
//     MAX_WAIT=4, no ack -> FetchError=1 after 4 REQ cycles; ack on 4th REQ cycle -> accepted.
//  6. Reset asserted mid-REQ with ack pending -> outputs at reset values immediately; refetch from RESET_PC.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - MIPS instruction fetch sequencer with req/ack imem port
// Holds the PC, fetches one word per request, and resolves jump/branch/jr targets at retire.
module mips_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruction,
   output logic [5:0]  InstrOpCode,
   output logic        InstrValid,
   input  logic        InstrReady,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        Zero,
   input  logic        JumpReg,
   input  logic [31:0] RegTarget,
   output logic [31:0] LinkPC,
   output logic [31:0] InstrCount,
   output logic        FetchError
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_ERR} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] count_q;
   logic [7:0]  wait_q;
   logic        req_q;
   logic        valid_q;
   logic        err_q;

   logic [31:0] link_pc;
   logic [31:0] branch_off;
   logic [31:0] pc_d;
   logic        taken;
   logic        jr_misaligned;

   always_comb begin
      link_pc       = pc_q + 32'd4;
      branch_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      // Opcode bit 0 distinguishes bne from beq, so it flips the sense of Zero.
      taken         = Branch & (Zero ^ instr_q[26]);
      jr_misaligned = JumpReg & (RegTarget[1:0] != 2'b00);
      pc_d          = link_pc;
      if (JumpReg)
         pc_d = RegTarget;
      else if (Jump)
         pc_d = {link_pc[31:28], instr_q[25:0], 2'b00};
      else if (taken)
         pc_d = link_pc + branch_off;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
         count_q <= 32'd0;
         wait_q  <= 8'd0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q <= S_REQ;
               req_q   <= 1'b1;
            end
            S_REQ: begin
               if (imem_ack) begin
                  instr_q <= imem_rdata;
                  valid_q <= 1'b1;
                  req_q   <= 1'b0;
                  state_q <= S_HOLD;
               end else if (wait_q == WAIT_LAST) begin
                  req_q   <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_ERR;
               end else begin
                  wait_q  <= wait_q + 8'd1;
               end
            end
            S_HOLD: begin
               if (InstrReady) begin
                  valid_q <= 1'b0;
                  if (jr_misaligned) begin
                     err_q   <= 1'b1;
                     state_q <= S_ERR;
                  end else begin
                     pc_q    <= pc_d;
                     count_q <= count_q + 32'd1;
                     wait_q  <= 8'd0;
                     req_q   <= 1'b1;
                     state_q <= S_REQ;
                  end
               end
            end
            default: begin
               req_q   <= 1'b0;
               valid_q <= 1'b0;
               err_q   <= 1'b1;
            end
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign Instruction = instr_q;
   assign InstrOpCode = instr_q[31:26];
   assign InstrValid  = valid_q;
   assign LinkPC      = link_pc;
   assign InstrCount  = count_q;
   assign FetchError  = err_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - directed self-checking bench for mips_fetch_unit
module tb_mips_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] Instruction;
   logic [5:0]  InstrOpCode;
   logic        InstrValid;
   logic        InstrReady = 1'b0;
   logic        Jump = 1'b0;
   logic        Branch = 1'b0;
   logic        Zero = 1'b0;
   logic        JumpReg = 1'b0;
   logic [31:0] RegTarget = 32'd0;
   logic [31:0] LinkPC;
   logic [31:0] InstrCount;
   logic        FetchError;

   int n_checks = 0;
   int n_errors = 0;

   mips_fetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .Instruction(Instruction), .InstrOpCode(InstrOpCode), .InstrValid(InstrValid),
      .InstrReady(InstrReady), .Jump(Jump), .Branch(Branch), .Zero(Zero),
      .JumpReg(JumpReg), .RegTarget(RegTarget), .LinkPC(LinkPC),
      .InstrCount(InstrCount), .FetchError(FetchError)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " req"},   32'(imem_req),   32'd0);
      check({tag, " addr"},  imem_addr,       32'h0);
      check({tag, " link"},  LinkPC,          32'h4);
      check({tag, " valid"}, 32'(InstrValid), 32'd0);
      check({tag, " instr"}, Instruction,     32'h0);
      check({tag, " op"},    32'(InstrOpCode),32'd0);
      check({tag, " count"}, InstrCount,      32'd0);
      check({tag, " err"},   32'(FetchError), 32'd0);
   endtask

   // Called just after an edge that left the DUT in REQ with a fresh wait count.
   task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int delay);
      check("fetch req", 32'(imem_req), 32'd1);
      check("fetch addr", imem_addr, exp_addr);
      for (int i = 0; i < delay; i++) begin
         step();
         check("wait req", 32'(imem_req), 32'd1);
         check("wait addr", imem_addr, exp_addr);
         check("wait valid", 32'(InstrValid), 32'd0);
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      check("hold valid", 32'(InstrValid), 32'd1);
      check("hold instr", Instruction, word);
      check("hold op", 32'(InstrOpCode), 32'(word[31:26]));
      check("hold req", 32'(imem_req), 32'd0);
   endtask

   task automatic retire(input logic j, input logic br, input logic z, input logic jr,
                         input logic [31:0] tgt);
      Jump = j; Branch = br; Zero = z; JumpReg = jr; RegTarget = tgt;
      InstrReady = 1'b1;
      step();
      InstrReady = 1'b0;
      Jump = 1'b0; Branch = 1'b0; Zero = 1'b0; JumpReg = 1'b0; RegTarget = 32'h0;
   endtask

   initial begin
      step();
      step();
      check_reset_outputs("rst");
      reset = 1'b0;
      check("idle req", 32'(imem_req), 32'd0);
      step();

      // Zero-wait sequential fetches
      for (int i = 0; i < 4; i++) begin
         fetch(32'(4 * i), 32'h0000_0020 + 32'(i), 0);
         retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         check("seq count", InstrCount, 32'(i + 1));
      end

      // beq at 0x10 with delayed ack and stalled retire; acks in HOLD must be ignored
      fetch(32'h10, 32'h1000_FFFF, 3);
      for (int i = 0; i < 5; i++) begin
         imem_ack = 1'b1;
         imem_rdata = 32'hDEAD_BEEF;
         step();
         check("stall instr", Instruction, 32'h1000_FFFF);
         check("stall count", InstrCount, 32'd4);
         check("stall req", 32'(imem_req), 32'd0);
      end
      imem_ack = 1'b0;
      retire(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("beq taken count", InstrCount, 32'd5);
      fetch(32'h10, 32'h1400_FFFF, 0);
      retire(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      fetch(32'h10, 32'h1000_FFFF, 0);
      retire(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         fetch(32'h14 + 32'(4 * i), 32'h0, 0);
         retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      end

      // jal, then jr beating Jump, then misaligned jr
      fetch(32'h20, 32'h0C00_0040, 0);
      check("jal link", LinkPC, 32'h24);
      retire(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      fetch(32'h100, 32'h0, 0);
      retire(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
      check("jr count", InstrCount, 32'd12);
      fetch(32'h200, 32'h0, 0);
      retire(1'b0, 1'b0, 1'b0, 1'b1, 32'h202);
      check("jr err", 32'(FetchError), 32'd1);
      check("jr err req", 32'(imem_req), 32'd0);
      check("jr err valid", 32'(InstrValid), 32'd0);
      check("jr err addr", imem_addr, 32'h200);
      check("jr err count", InstrCount, 32'd12);
      imem_ack = 1'b1;
      step();
      step();
      imem_ack = 1'b0;
      check("err sticky", 32'(FetchError), 32'd1);
      check("err req", 32'(imem_req), 32'd0);

      // Timeout after MAX_WAIT=4 REQ cycles
      reset = 1'b1;
      step();
      check_reset_outputs("rst2");
      reset = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         check("to req", 32'(imem_req), 32'd1);
         check("to err", 32'(FetchError), 32'd0);
      end
      step();
      check("timeout err", 32'(FetchError), 32'd1);
      check("timeout req", 32'(imem_req), 32'd0);

      // Ack on the 4th REQ cycle is accepted
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      fetch(32'h0, 32'h0000_1234, 3);
      check("late ack err", 32'(FetchError), 32'd0);
      retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("late addr", imem_addr, 32'h4);

      // Async reset mid-REQ with an ack pending
      imem_ack = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("async");
      imem_ack = 1'b0;
      step();
      reset = 1'b0;
      step();
      fetch(32'h0, 32'h0, 0);

      // PC wrap: LinkPC of 0xFFFFFFFC is 0
      retire(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      fetch(32'hFFFF_FFFC, 32'h0, 0);
      check("wrap link", LinkPC, 32'h0);
      retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("wrap addr", imem_addr, 32'h0);
      check("wrap count", InstrCount, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
